phase_driver: RTL and testbench
===============================

# phase_driver

Three-phase hall-commutated PWM output stage for the BLDC motor controller. Decodes the 3-bit hall code into a six-step commutation pattern, generates a centre-less, edge-aligned PWM from a free-running counter, and drives complementary high/low gate outputs per phase with dead-time insertion. It sits between the motor state machine, which supplies `en` and `duty_cycle`, and the gate-driver pins.

## Interface
- `MAX_COUNTER`, `'h3FF`: last PWM counter value; period = MAX_COUNTER+1 clocks.
- `COUNTER_WIDTH`, `$clog2(MAX_COUNTER)`: PWM counter width.
- `MAX_DUTY_CYCLE`, `'h3FF`: full-scale duty value, meaning 100 %.
- `DUTY_CYCLE_WIDTH`, `$clog2(MAX_DUTY_CYCLE)`: duty input width.
- `DUTY_CYCLE_STEP_RES`, `1`: counter counts per duty LSB.
- `DEAD_TIME`, `2`: minimum clocks with both gates off before any gate turns on.
- `clk` in 1: clock.
- `rst_n` in 1: reset. One clock; reset is asynchronous and active-low.
- `en` in 1: 0 forces all phases to float.
- `hall` in 3: hall code, bit0=A, bit1=B, bit2=C.
- `duty_cycle` in DUTY_CYCLE_WIDTH: PWM duty for the driven phase.
- `phase_h` out 3: high-side gate per phase (bit0=A).
- `phase_l` out 3: low-side gate per phase.

## Operation
- Commutation decode (combinational): each hall code gives `u` (PWM phase) and `z` (floating phase).
  - 101 gives A PWM, B low, C float.
  - 100 gives A PWM, C low, B float.
  - 110 gives B PWM, C low, A float.
  - 010 gives B PWM, A low, C float.
  - 011 gives C PWM, A low, B float.
  - 001 gives C PWM, B low, A float.
  - 000 and 111 are invalid: all phases float.
- Per-phase duty: `duty_cycle` if `u[j]`, else 0. Floating if `z[j]` or `!en`.
- PWM counter: free-running 0..MAX_COUNTER, then wraps to 0. It runs whenever out of reset, regardless of `en`.
- Threshold: `duty*DUTY_CYCLE_STEP_RES`.
  - `duty >= MAX_DUTY_CYCLE` gives 100 % high.
  - Duty 0 gives 100 % low.
- Target per phase:
  - OFF if floating.
  - HIGH if counter < threshold.
  - LOW otherwise.
- Output per phase:
  - OFF target: both gates 0 on the next edge.
  - HIGH/LOW target: the corresponding gate asserts only after both gates have been 0 for DEAD_TIME consecutive clocks.
  - A HIGH↔LOW change drops the active gate on the next edge, then inserts the dead time.
  - DEAD_TIME=0 switches directly.
- Invariant: `phase_h[j] & phase_l[j]` is never 1.

## Timing
- Reset: `phase_h`/`phase_l` = 0, PWM counter = 0, dead-time counters = 0, all asynchronous.
- All outputs are registered. A change on `hall`/`en`/`duty_cycle` reaches the outputs 1 clock later; turn-on edges additionally wait DEAD_TIME clocks.
- Duty is sampled every clock, with no period-boundary latching. A mid-period duty change takes effect on the next compare.
- Hall change mid-PWM-period: the new pattern applies from the next edge, with dead time enforced per phase.
- Reset asserted mid-operation forces all gates off immediately.

## Configuration
- `PHASE_DRIVER_HALL_SYNC_EN` defined: `hall` passes through a 2-flop synchronizer (reset 3'b111, i.e. float) before decode. Hall-to-output latency becomes 3 clocks.
- Undefined: `hall` is decoded directly. The input must already be synchronous.

## Structure
- Shared package holds:
  - the hall code constants (valid sequence, invalid 000/111);
  - the per-phase target enum {OFF, HIGH, LOW};
  - the default parameter values.
- Sub-module `hall_effect_sensor`: pure combinational hall to `u`/`z` decode, instantiated once.
- The PWM counter is shared. The dead-time/gate logic is replicated 3× in a generate loop.

## Test plan
- Reset: `rst_n`=0 while `hall`=101, duty=512, `en`=1 → all six gates 0 immediately; counter restarts at 0 after release.
- `hall`=101, duty=512, `en`=1, defaults → per 1024-clock period:
  - `phase_h[0]` high 510 clocks, `phase_l[0]` high 510 clocks, with two 2-clock both-off gaps;
  - `phase_l[1]` constantly 1;
  - phase C both 0.
- `hall`=000, then 111 → all gates 0 within 1 clock, for any duty.
- `en` 1→0 with valid hall → all gates 0 on the next edge. `en` 0→1 → first gate asserts after 2 dead-time clocks.
- duty=1023, `hall`=010 → `phase_h[1]` constantly 1 and `phase_l[0]` constantly 1. duty=0 → `phase_l[1]` constantly 1 and `phase_h[1]` never 1.
- `hall` 101→100 → B both 0 on the next edge; C `phase_l` asserts after 2 clocks; A PWM is uninterrupted. At no cycle is any phase both-high.

Source files
------------

// File: rtl/phase_driver_pkg.sv
// Shared definitions for the three-phase hall-commutated PWM gate driver:
// hall code constants, per-phase target encoding and default parameters.
package phase_driver_pkg;

    localparam int MAX_COUNTER_DEF         = 'h3FF;
    localparam int MAX_DUTY_CYCLE_DEF      = 'h3FF;
    localparam int DUTY_CYCLE_STEP_RES_DEF = 1;
    localparam int DEAD_TIME_DEF           = 2;

    // Valid six-step hall sequence, bit0=A, bit1=B, bit2=C
    localparam logic [2:0] HALL_S0 = 3'b101;
    localparam logic [2:0] HALL_S1 = 3'b100;
    localparam logic [2:0] HALL_S2 = 3'b110;
    localparam logic [2:0] HALL_S3 = 3'b010;
    localparam logic [2:0] HALL_S4 = 3'b011;
    localparam logic [2:0] HALL_S5 = 3'b001;
    localparam logic [2:0] HALL_INV_LO = 3'b000;
    localparam logic [2:0] HALL_INV_HI = 3'b111;

    typedef enum logic [1:0] {
        TGT_OFF,
        TGT_HIGH,
        TGT_LOW
    } target_e;

endpackage

// File: rtl/phase_driver_hall_effect_sensor.sv
// Combinational hall decode: u marks the PWM phase, z the floating phase.
// Invalid codes float every phase.
module hall_effect_sensor
    import phase_driver_pkg::*;
(
    input  logic [2:0] hall,
    output logic [2:0] u,
    output logic [2:0] z
);

    always_comb begin
        u = 3'b000;
        z = 3'b111;
        case (hall)
            HALL_S0: begin u = 3'b001; z = 3'b100; end
            HALL_S1: begin u = 3'b001; z = 3'b010; end
            HALL_S2: begin u = 3'b010; z = 3'b001; end
            HALL_S3: begin u = 3'b010; z = 3'b100; end
            HALL_S4: begin u = 3'b100; z = 3'b010; end
            HALL_S5: begin u = 3'b100; z = 3'b001; end
            HALL_INV_LO, HALL_INV_HI: begin u = 3'b000; z = 3'b111; end
        endcase
    end

endmodule

// File: rtl/phase_driver.sv
// Six-step PWM output stage with per-phase dead-time insertion.
// Define PHASE_DRIVER_HALL_SYNC_EN to add a 2-flop synchronizer on hall.
module phase_driver
    import phase_driver_pkg::*;
#(
    parameter int MAX_COUNTER         = MAX_COUNTER_DEF,
    parameter int COUNTER_WIDTH       = $clog2(MAX_COUNTER),
    parameter int MAX_DUTY_CYCLE      = MAX_DUTY_CYCLE_DEF,
    parameter int DUTY_CYCLE_WIDTH    = $clog2(MAX_DUTY_CYCLE),
    parameter int DUTY_CYCLE_STEP_RES = DUTY_CYCLE_STEP_RES_DEF,
    parameter int DEAD_TIME           = DEAD_TIME_DEF
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        en,
    input  logic [2:0]                  hall,
    input  logic [DUTY_CYCLE_WIDTH-1:0] duty_cycle,
    output logic [2:0]                  phase_h,
    output logic [2:0]                  phase_l
);

    localparam int DT_W = (DEAD_TIME > 1) ? $clog2(DEAD_TIME) : 1;
    localparam logic [DT_W-1:0] DT_M1 = DT_W'((DEAD_TIME > 0) ? DEAD_TIME - 1 : 0);

    logic [2:0] hall_dec;

`ifdef PHASE_DRIVER_HALL_SYNC_EN
    logic [2:0] hall_s1_q, hall_s2_q;
    // Reset to an invalid code so the outputs float until hall settles
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hall_s1_q <= HALL_INV_HI;
            hall_s2_q <= HALL_INV_HI;
        end else begin
            hall_s1_q <= hall;
            hall_s2_q <= hall_s1_q;
        end
    end
    assign hall_dec = hall_s2_q;
`else
    assign hall_dec = hall;
`endif

    logic [2:0] u, z;

    hall_effect_sensor u_hall (
        .hall (hall_dec),
        .u    (u),
        .z    (z)
    );

    logic [COUNTER_WIDTH-1:0] pwm_cnt_q, pwm_cnt_d;

    always_comb begin
        pwm_cnt_d = (pwm_cnt_q == COUNTER_WIDTH'(MAX_COUNTER)) ? '0 : pwm_cnt_q + 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) pwm_cnt_q <= '0;
        else        pwm_cnt_q <= pwm_cnt_d;
    end

    for (genvar j = 0; j < 3; j++) begin : g_phase
        logic [DUTY_CYCLE_WIDTH-1:0] duty_j;
        logic [31:0]                 thr_j;
        target_e                     tgt;
        logic                        ok;
        logic                        h_q, h_d, l_q, l_d;
        logic [DT_W-1:0]             dt_q, dt_d;

        always_comb begin
            duty_j = u[j] ? duty_cycle : '0;
            thr_j  = 32'(duty_j) * 32'(DUTY_CYCLE_STEP_RES);
            if (z[j] || !en)
                tgt = TGT_OFF;
            else if ((32'(duty_j) >= 32'(MAX_DUTY_CYCLE)) || (32'(pwm_cnt_q) < thr_j))
                tgt = TGT_HIGH;
            else
                tgt = TGT_LOW;

            // A gate may turn on only once both gates have been off long enough
            // with an active target; floating restarts the dead-time count.
            ok  = (DEAD_TIME == 0) || (!h_q && !l_q && (dt_q >= DT_M1));
            h_d = (tgt == TGT_HIGH) && (h_q || ok);
            l_d = (tgt == TGT_LOW)  && (l_q || ok);

            if (h_q || l_q || (tgt == TGT_OFF)) dt_d = '0;
            else if (dt_q >= DT_M1)             dt_d = dt_q;
            else                                dt_d = dt_q + 1'b1;
        end

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                h_q  <= 1'b0;
                l_q  <= 1'b0;
                dt_q <= '0;
            end else begin
                h_q  <= h_d;
                l_q  <= l_d;
                dt_q <= dt_d;
            end
        end

        assign phase_h[j] = h_q;
        assign phase_l[j] = l_q;
    end

endmodule

// File: tb/tb_phase_driver.sv
// Scoreboard bench for phase_driver: stimulus queues expected gate states per
// cycle, a negedge monitor pops and compares them.
module tb_phase_driver;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       en;
    logic [2:0] hall;
    logic [9:0] duty_cycle;
    logic [2:0] phase_h;
    logic [2:0] phase_l;

    phase_driver dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .en         (en),
        .hall       (hall),
        .duty_cycle (duty_cycle),
        .phase_h    (phase_h),
        .phase_l    (phase_l)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int         at;
        logic [2:0] h;
        logic [2:0] l;
        string      name;
    } exp_t;

    exp_t sb[$];
    int passed  = 0;
    int total   = 0;
    int overlap = 0;

    task automatic exp_at(input int at, input logic [2:0] h, input logic [2:0] l, input string name);
        sb.push_back('{at, h, l, name});
    endtask

    task automatic chk(input string name, input int act, input int req);
        total++;
        if (act == req) passed++;
        else $display("FAIL %s: got %0d expected %0d", name, act, req);
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Monitor
    always @(negedge clk) begin
        exp_t e;
        if ((phase_h & phase_l) !== 3'b000) overlap++;
        while (sb.size() > 0 && sb[0].at <= cyc) begin
            e = sb.pop_front();
            total++;
            if (e.at != cyc)
                $display("FAIL %s: sample missed, now cycle %0d due %0d", e.name, cyc, e.at);
            else if (phase_h === e.h && phase_l === e.l)
                passed++;
            else
                $display("FAIL %s: cycle %0d h=%b l=%b expected h=%b l=%b",
                         e.name, cyc, phase_h, phase_l, e.h, e.l);
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
        $fatal(1);
    end

    initial begin
        int e0, n, m;
        int cnt_h, cnt_l, cnt_lb, cnt_c;
        rst_n = 1'b0; en = 1'b1; hall = 3'b101; duty_cycle = 10'd512;

        // Reset held with active inputs, then release: counter starts at 0
        tick(2);
        exp_at(cyc, 3'b000, 3'b000, "reset_hold");
        tick(1);
        rst_n = 1'b1;
        e0 = cyc + 1;
        exp_at(e0,        3'b000, 3'b000, "post_rst_dead");
        exp_at(e0 + 1,    3'b001, 3'b010, "a_first_on");
        exp_at(e0 + 511,  3'b001, 3'b010, "a_high_end");
        exp_at(e0 + 512,  3'b000, 3'b010, "a_drop");
        exp_at(e0 + 513,  3'b000, 3'b010, "a_gap");
        exp_at(e0 + 514,  3'b000, 3'b011, "a_low_on");
        exp_at(e0 + 1023, 3'b000, 3'b011, "a_low_end");
        exp_at(e0 + 1024, 3'b000, 3'b010, "wrap_gap0");
        exp_at(e0 + 1025, 3'b000, 3'b010, "wrap_gap1");
        exp_at(e0 + 1026, 3'b001, 3'b010, "a_high_on");
        while (cyc < e0 + 1024) tick(1);
        cnt_h = 0; cnt_l = 0; cnt_lb = 0; cnt_c = 0;
        for (int k = 0; k < 1024; k++) begin
            @(negedge clk);
            if (phase_h[0]) cnt_h++;
            if (phase_l[0]) cnt_l++;
            if (phase_l[1]) cnt_lb++;
            if (phase_h[2] || phase_l[2]) cnt_c++;
        end
        chk("period_a_high", cnt_h, 510);
        chk("period_a_low", cnt_l, 510);
        chk("period_b_low", cnt_lb, 1024);
        chk("period_c_off", cnt_c, 0);

        // Mid-operation reset
        tick(1);
        rst_n = 1'b0;
        exp_at(cyc, 3'b000, 3'b000, "mid_rst_off");
        tick(2);
        rst_n = 1'b1;
        e0 = cyc + 1;
        exp_at(e0,       3'b000, 3'b000, "restart_dead");
        exp_at(e0 + 1,   3'b001, 3'b010, "restart_on");
        exp_at(e0 + 511, 3'b001, 3'b010, "restart_high_end");
        exp_at(e0 + 512, 3'b000, 3'b010, "restart_drop");
        while (cyc < e0 + 520) tick(1);

        // Invalid hall codes
        hall = 3'b000;
        n = cyc;
        exp_at(n + 1, 3'b000, 3'b000, "hall000_next");
        exp_at(n + 7, 3'b000, 3'b000, "hall000_hold");
        tick(8);
        hall = 3'b111; duty_cycle = 10'd1023;
        n = cyc;
        exp_at(n + 1, 3'b000, 3'b000, "hall111_next");
        exp_at(n + 5, 3'b000, 3'b000, "hall111_hold");
        tick(6);

        // Enable toggling
        hall = 3'b101;
        tick(5);
        exp_at(cyc, 3'b001, 3'b010, "full_settled");
        en = 1'b0;
        n = cyc;
        exp_at(n + 1, 3'b000, 3'b000, "en_off");
        tick(4);
        en = 1'b1;
        n = cyc;
        exp_at(n + 1, 3'b000, 3'b000, "en_on_dead");
        exp_at(n + 2, 3'b001, 3'b010, "en_on_assert");
        tick(4);

        // Full and zero duty with hall 010
        hall = 3'b010;
        n = cyc;
        exp_at(n + 1,   3'b000, 3'b000, "swap_both_off");
        exp_at(n + 3,   3'b010, 3'b001, "full_b_on");
        exp_at(n + 300, 3'b010, 3'b001, "full_hold0");
        exp_at(n + 900, 3'b010, 3'b001, "full_hold1");
        while (cyc < n + 1000) tick(1);
        duty_cycle = 10'd0;
        m = cyc;
        exp_at(m + 1,   3'b000, 3'b001, "zero_b_drop");
        exp_at(m + 3,   3'b000, 3'b011, "zero_b_low");
        exp_at(m + 600, 3'b000, 3'b011, "zero_hold");
        while (cyc < m + 610) tick(1);

        // Commutation 101 -> 100 while A is in its high window
        hall = 3'b101; duty_cycle = 10'd512;
        n = cyc;
        while (cyc < n + 1030 || ((cyc + 1 - e0) % 1024) != 100) tick(1);
        exp_at(cyc, 3'b001, 3'b010, "pre_commute");
        hall = 3'b100;
        n = cyc;
        exp_at(n + 1, 3'b001, 3'b000, "b_float");
        exp_at(n + 2, 3'b001, 3'b100, "c_low_on");
        exp_at(n + 3, 3'b001, 3'b100, "c_low_hold");
        tick(5);

        chk("no_shoot_through", overlap, 0);
        chk("sb_drained", sb.size(), 0);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
